// File: rtl/fp_div_seq.sv
// Sequential restoring divider for 31-bit unsigned float magnitudes
// (8-bit exponent, bias 127, 23-bit mantissa). Specials resolve in one
// cycle; normal operands take 25 quotient cycles plus one normalise cycle.
// Results are truncated and flushed to zero on underflow.
module fp_div_seq #(
  parameter int unsigned QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [30:0] a,
  input  logic [30:0] b,
  output logic        busy,
  output logic        done,
  output logic [30:0] out,
  output logic        err_INF,
  output logic        div0,
  output logic        ovf,
  output logic        unf
);

  localparam int unsigned WW = 31;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned RW = 26;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 5;
  localparam int unsigned XW = 10;

  localparam logic [WW-1:0] VAL_NAN = 31'h7FFF_FFFF;
  localparam logic [WW-1:0] VAL_INF = 31'h7F80_0000;
  localparam logic [WW-1:0] VAL_ZERO = 31'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0]    out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [EW-1:0]    ea_q, ea_d;
  logic [EW-1:0]    eb_q, eb_d;
  logic [RW-1:0]    r_q, r_d;
  logic [DW-1:0]    dv_q, dv_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand field decode
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_exp  = a[WW-1:MW];
  assign b_exp  = b[WW-1:MW];
  assign a_man  = a[MW-1:0];
  assign b_man  = b[MW-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_man == '0);
  assign b_inf  = (b_exp == '1) && (b_man == '0);
  assign a_nan  = (a_exp == '1) && (a_man != '0);
  assign b_nan  = (b_exp == '1) && (b_man != '0);

  // Special-operand resolution, first match wins
  logic          spec_c;
  logic [WW-1:0] spec_out_c;
  logic          spec_err_c;
  logic          spec_div0_c;

  always_comb begin
    spec_c      = 1'b1;
    spec_out_c  = VAL_ZERO;
    spec_err_c  = 1'b0;
    spec_div0_c = 1'b0;
    if (a_nan || b_nan) begin
      spec_out_c = VAL_NAN;
      spec_err_c = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_out_c = VAL_NAN;
      spec_err_c = 1'b1;
    end else if (a_inf) begin
      spec_out_c = VAL_INF;
    end else if (b_zero) begin
      spec_out_c  = VAL_INF;
      spec_div0_c = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_out_c = VAL_ZERO;
    end else begin
      spec_c = 1'b0;
    end
  end

  // One restoring step: compare, conditionally subtract, shift
  logic          ge_c;
  logic [RW-1:0] diff_c;

  assign ge_c   = (r_q >= RW'(dv_q));
  assign diff_c = r_q - RW'(dv_q);

  // Normalisation of the finished quotient
  logic signed [XW-1:0] e_c;
  logic [MW-1:0]        mant_c;

  assign e_c    = $signed(XW'(ea_q)) - $signed(XW'(eb_q))
                + (q_q[QBITS-1] ? 10'sd127 : 10'sd126);
  assign mant_c = q_q[QBITS-1] ? q_q[QBITS-2:1] : q_q[MW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !spec_c) state_d = S_DIV;
      S_DIV:  if (cnt_q == CW'(QBITS - 1)) state_d = S_NORM;
      S_NORM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    out_d  = out_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = err_q;
    div0_d = div0_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    r_d    = r_q;
    dv_d   = dv_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (spec_c) begin
            out_d  = spec_out_c;
            err_d  = spec_err_c;
            div0_d = spec_div0_c;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            ea_d   = a_exp;
            eb_d   = b_exp;
            r_d    = RW'({1'b1, a_man});
            dv_d   = {1'b1, b_man};
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
          end
        end
      end
      S_DIV: begin
        r_d   = ge_c ? {diff_c[RW-2:0], 1'b0} : {r_q[RW-2:0], 1'b0};
        q_d   = {q_q[QBITS-2:0], ge_c};
        cnt_d = cnt_q + CW'(1);
      end
      S_NORM: begin
        err_d  = 1'b0;
        div0_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (e_c >= 10'sd255) begin
          out_d = VAL_INF;
          ovf_d = 1'b1;
        end else if (e_c <= 10'sd0) begin
          out_d = VAL_ZERO;
          unf_d = 1'b1;
        end else begin
          out_d = {e_c[EW-1:0], mant_c};
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      r_q    <= '0;
      dv_q   <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      div0_q <= div0_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      r_q    <= r_d;
      dv_q   <= dv_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_INF = err_q;
  assign div0    = div0_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: normal quotients, specials, exponent
// range limits, ignored starts, mid-division reset and back-to-back issue.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [30:0] a_i;
  logic [30:0] b_i;
  logic        busy;
  logic        done;
  logic [30:0] out;
  logic        err_INF;
  logic        div0;
  logic        ovf;
  logic        unf;

  int n_pass;
  int n_total;

  fp_div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .err_INF (err_INF),
    .div0    (div0),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for done. lat = edges after the accepting
  // edge at which done is first seen (0 = cycle right after the start edge).
  task automatic issue(input logic [30:0] av, input logic [30:0] bv,
                       output int lat, output int busy_cnt, output bit tmo);
    @(negedge clk);
    a_i = av; b_i = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = 31'h1234_5678; b_i = 31'h0ABC_DEF0;
    lat = 0; busy_cnt = 0; tmo = 1'b0;
    if (busy) busy_cnt++;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({out, busy, done, err_INF, div0, ovf, unf} !== 37'd0)
      $display("FAIL reset_state: got out=%h busy=%b done=%b flags=%b%b%b%b, want all 0",
               out, busy, done, err_INF, div0, ovf, unf);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_normal();
    int lat, bc; bit tmo;
    logic [30:0] av [3] = '{31'h3F80_0000, 31'h40C0_0000, 31'h3F80_0000};
    logic [30:0] bv [3] = '{31'h3F80_0000, 31'h4000_0000, 31'h4040_0000};
    logic [30:0] ev [3] = '{31'h3F80_0000, 31'h4040_0000, 31'h3EAA_AAAA};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i], lat, bc, tmo);
      n_total++;
      if (tmo || lat != 26) $display("FAIL norm_latency[%0d]: got %0d (timeout=%b), want 26", i, lat, tmo);
      else n_pass++;
      n_total++;
      if (out !== ev[i]) $display("FAIL norm_out[%0d]: got %h, want %h", i, out, ev[i]);
      else n_pass++;
      n_total++;
      if ({err_INF, div0, ovf, unf} !== 4'b0000)
        $display("FAIL norm_flags[%0d]: got %b, want 0000", i, {err_INF, div0, ovf, unf});
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (bc != 26) $display("FAIL norm_busy_cycles: got %0d, want 26", bc);
        else n_pass++;
      end
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || out !== ev[i])
        $display("FAIL done_pulse_hold[%0d]: got done=%b out=%h, want done=0 out=%h", i, done, out, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_special();
    int lat, bc; bit tmo;
    // flags order: err_INF, div0, ovf, unf
    logic [30:0] av [5] = '{31'h0000_0000, 31'h3F80_0000, 31'h7F80_0000, 31'h7FC0_0000, 31'h0000_0000};
    logic [30:0] bv [5] = '{31'h0000_0000, 31'h0000_0000, 31'h7F80_0000, 31'h3F80_0000, 31'h7F80_0000};
    logic [30:0] ev [5] = '{31'h7FFF_FFFF, 31'h7F80_0000, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h0000_0000};
    logic [3:0]  fv [5] = '{4'b1000, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      issue(av[i], bv[i], lat, bc, tmo);
      n_total++;
      if (tmo || lat != 0) $display("FAIL spec_latency[%0d]: got %0d (timeout=%b), want 0", i, lat, tmo);
      else n_pass++;
      n_total++;
      if (out !== ev[i] || {err_INF, div0, ovf, unf} !== fv[i])
        $display("FAIL spec_result[%0d]: got out=%h flags=%b, want out=%h flags=%b",
                 i, out, {err_INF, div0, ovf, unf}, ev[i], fv[i]);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL spec_busy[%0d]: got %b, want 0", i, busy);
      else n_pass++;
    end
  endtask

  task automatic test_exp_range();
    int lat, bc; bit tmo;
    issue(31'h7F00_0000, 31'h3E80_0000, lat, bc, tmo);
    n_total++;
    if (tmo || out !== 31'h7F80_0000 || {err_INF, div0, ovf, unf} !== 4'b0010)
      $display("FAIL overflow: got out=%h flags=%b timeout=%b, want out=7f800000 flags=0010",
               out, {err_INF, div0, ovf, unf}, tmo);
    else n_pass++;
    issue(31'h0080_0000, 31'h4000_0000, lat, bc, tmo);
    n_total++;
    if (tmo || out !== 31'h0000_0000 || {err_INF, div0, ovf, unf} !== 4'b0001)
      $display("FAIL underflow: got out=%h flags=%b timeout=%b, want out=00000000 flags=0001",
               out, {err_INF, div0, ovf, unf}, tmo);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    a_i = 31'h3F80_0000; b_i = 31'h4040_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      if (k == 4) begin a_i = 31'h40C0_0000; b_i = 31'h4000_0000; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    n_total++;
    if (k != 26 || out !== 31'h3EAA_AAAA)
      $display("FAIL ignore_start: got done at %0d out=%h, want 26 out=3eaaaaaa", k, out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, n_done; bit tmo;
    @(negedge clk);
    a_i = 31'h3F80_0000; b_i = 31'h3F80_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({out, busy, done, err_INF, div0, ovf, unf} !== 37'd0)
      $display("FAIL mid_reset_state: got out=%h busy=%b done=%b flags=%b%b%b%b, want all 0",
               out, busy, done, err_INF, div0, ovf, unf);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_total++;
    if (n_done != 0) $display("FAIL mid_reset_no_done: got %0d done pulses, want 0", n_done);
    else n_pass++;
    issue(31'h40C0_0000, 31'h4000_0000, lat, bc, tmo);
    n_total++;
    if (tmo || lat != 26 || out !== 31'h4040_0000)
      $display("FAIL post_reset_div: got lat=%0d out=%h timeout=%b, want 26 40400000", lat, out, tmo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k, first_k, second_k;
    @(negedge clk);
    a_i = 31'h7F00_0000; b_i = 31'h3E80_0000; start = 1'b1;
    @(posedge clk); #1;
    a_i = 31'h40C0_0000; b_i = 31'h4000_0000;
    k = 0; first_k = -1; second_k = -1;
    while (second_k < 0 && k < 80) begin
      @(posedge clk); #1;
      k++;
      if (done && first_k < 0) begin
        first_k = k;
        n_total++;
        if (out !== 31'h7F80_0000 || {err_INF, div0, ovf, unf} !== 4'b0010)
          $display("FAIL b2b_first: got out=%h flags=%b, want 7f800000 0010", out, {err_INF, div0, ovf, unf});
        else n_pass++;
      end else if (done) begin
        second_k = k;
      end
      if (first_k > 0 && k == first_k + 1) begin
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_accept_in_done_cycle: got busy=%b, want 1", busy);
        else n_pass++;
      end
    end
    start = 1'b0;
    n_total++;
    if (first_k != 26 || second_k != 53)
      $display("FAIL b2b_timing: got done at %0d and %0d, want 26 and 53", first_k, second_k);
    else n_pass++;
    n_total++;
    if (out !== 31'h4040_0000 || {err_INF, div0, ovf, unf} !== 4'b0000)
      $display("FAIL b2b_second: got out=%h flags=%b, want 40400000 0000", out, {err_INF, div0, ovf, unf});
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_normal();
    test_special();
    test_exp_range();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
